// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush detection plus multi-cycle MUL sequencing.
// In: ID/EX operands and control. Out: Stall/Bubble/Flush, MulStart/Busy/WB/Rd.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] IFID_rs1_i,
  input  logic [4:0] IFID_rs2_i,
  input  logic       IFID_UsesRs2_i,
  input  logic [4:0] ID_rd_i,
  input  logic       ID_MulReq_i,
  input  logic [4:0] IDEX_rd_i,
  input  logic       IDEX_MemRead_i,
  input  logic       EX_BranchTaken_i,
  output logic       Stall_o,
  output logic       Bubble_o,
  output logic       Flush_o,
  output logic       MulStart_o,
  output logic       MulBusy_o,
  output logic       MulWB_o,
  output logic [4:0] MulRd_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [4:0] mul_rd_q;

  logic lu;
  logic raw;
  logic st;
  logic hz;
  logic start;
  logic idle;

  function automatic logic match(
    input logic [4:0] r,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use2
  );
    return (r != 5'd0) &&
           ((r == rs1) || (use2 && (r == rs2)));
  endfunction

  assign idle = (state_q == IDLE);

  assign lu = IDEX_MemRead_i &
              match(IDEX_rd_i, IFID_rs1_i,
                    IFID_rs2_i, IFID_UsesRs2_i);

  // Held through WB: the dedicated write port
  // only lands the result at the end of WB.
  assign raw = !idle &
               match(mul_rd_q, IFID_rs1_i,
                     IFID_rs2_i, IFID_UsesRs2_i);

  assign st = ID_MulReq_i & !idle;
  assign hz = lu | raw | st;

  assign start = ID_MulReq_i & idle &
                 !lu & !EX_BranchTaken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      mul_rd_q <= 5'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q    <= CNT_INIT;
        mul_rd_q <= ID_rd_i;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (cnt_q == 4'd1) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is
  // asserted, including input-driven terms.
  always_comb begin
    Flush_o    = rst_i & EX_BranchTaken_i;
    Stall_o    = rst_i & hz & !EX_BranchTaken_i;
    Bubble_o   = rst_i & (hz | EX_BranchTaken_i);
    MulStart_o = rst_i & start;
    MulBusy_o  = rst_i & !idle;
    MulWB_o    = rst_i & (state_q == WB);
    MulRd_o    = rst_i ? mul_rd_q : 5'd0;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus MUL timing sequences.
// Checks a MUL_LAT=4 instance and a MUL_LAT=2 instance.
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] rs1, rs2, id_rd, ex_rd;
  logic       u2, mreq, mrd, br;

  logic       stall, bubble, flush, start;
  logic       busy, wb;
  logic [4:0] mrd_o;
  logic       s2_stall, s2_bubble, s2_flush, s2_start;
  logic       s2_busy, s2_wb;
  logic [4:0] s2_mrd;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.MUL_LAT(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
    .IFID_UsesRs2_i(u2), .ID_rd_i(id_rd),
    .ID_MulReq_i(mreq), .IDEX_rd_i(ex_rd),
    .IDEX_MemRead_i(mrd),
    .EX_BranchTaken_i(br),
    .Stall_o(stall), .Bubble_o(bubble),
    .Flush_o(flush), .MulStart_o(start),
    .MulBusy_o(busy), .MulWB_o(wb),
    .MulRd_o(mrd_o)
  );

  hazard_ctrl #(.MUL_LAT(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
    .IFID_UsesRs2_i(u2), .ID_rd_i(id_rd),
    .ID_MulReq_i(mreq), .IDEX_rd_i(ex_rd),
    .IDEX_MemRead_i(mrd),
    .EX_BranchTaken_i(br),
    .Stall_o(s2_stall), .Bubble_o(s2_bubble),
    .Flush_o(s2_flush), .MulStart_o(s2_start),
    .MulBusy_o(s2_busy), .MulWB_o(s2_wb),
    .MulRd_o(s2_mrd)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] id_rd;
    logic       mreq;
    logic [4:0] ex_rd;
    logic       mrd;
    logic       br;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] o1();
    return {2'b0, stall, bubble, flush,
            start, busy, wb};
  endfunction

  task automatic idle_in();
    rs1 = 0; rs2 = 0; u2 = 0; id_rd = 0;
    mreq = 0; ex_rd = 0; mrd = 0; br = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // Advance to the next cycle's drive point.
  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    // {stall,bubble,flush,start}
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,
               4'b0000, "idle"};
    vt[1]  = '{0, 5, 1, 0, 0, 5, 1, 0,
               4'b1100, "lu_rs2"};
    vt[2]  = '{0, 5, 0, 0, 0, 5, 1, 0,
               4'b0000, "lu_rs2_unused"};
    vt[3]  = '{0, 0, 1, 0, 0, 0, 1, 0,
               4'b0000, "lu_rd0"};
    vt[4]  = '{9, 0, 0, 0, 0, 9, 1, 0,
               4'b1100, "lu_rs1"};
    vt[5]  = '{9, 0, 0, 0, 0, 9, 0, 0,
               4'b0000, "no_load"};
    vt[6]  = '{0, 0, 0, 7, 1, 0, 0, 0,
               4'b0001, "mul_issue"};
    vt[7]  = '{3, 0, 0, 7, 1, 3, 1, 0,
               4'b1100, "mul_lu"};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 1,
               4'b0110, "branch"};
    vt[9]  = '{3, 0, 0, 7, 1, 3, 1, 1,
               4'b0110, "branch_prio"};
    vt[10] = '{0, 0, 0, 0, 1, 0, 0, 0,
               4'b0001, "mul_rd0"};

    idle_in();
    rst_i = 1'b0;
    #1;
    chk("reset_outs", o1(), 8'h00);
    chk("reset_rd", {3'b0, mrd_o}, 8'h00);
    do_reset();

    // Reset pulses between vectors keep state IDLE.
    for (int i = 0; i < 11; i++) begin
      cyc();
      rst_i = 1'b1;
      rs1 = vt[i].rs1; rs2 = vt[i].rs2;
      u2 = vt[i].u2; id_rd = vt[i].id_rd;
      mreq = vt[i].mreq; ex_rd = vt[i].ex_rd;
      mrd = vt[i].mrd; br = vt[i].br;
      #1;
      chk(vt[i].name,
          {4'b0, stall, bubble, flush, start},
          {4'b0, vt[i].exp});
      rst_i = 1'b0;
    end
    cyc();
    idle_in();
    rst_i = 1'b1;

    // MUL timing, RAW through WB, structural stall
    cyc();
    mreq = 1; id_rd = 7;
    #1 chk("T0", o1(), 8'b0001_00);
    cyc();
    mreq = 0; id_rd = 0; rs1 = 7;
    #1 chk("T1", o1(), 8'b1100_10);
    cyc();
    mreq = 1; id_rd = 3;
    #1 chk("T2", o1(), 8'b1100_10);
    cyc();
    #1 chk("T3", o1(), 8'b1100_10);
    cyc();
    #1 chk("T4", o1(), 8'b1100_11);
    chk("T4_rd", {3'b0, mrd_o}, 8'd7);
    cyc();
    #1 chk("T5", o1(), 8'b0001_00);
    cyc();
    mreq = 0; id_rd = 0; rs1 = 3; br = 1;
    #1 chk("T6_br", o1(), 8'b0110_10);
    chk("T6_rd", {3'b0, mrd_o}, 8'd3);
    cyc();
    br = 0; mrd = 1; ex_rd = 3;
    #1 chk("T7_lu_raw", o1(), 8'b1100_10);
    cyc();
    mrd = 0; ex_rd = 0; rs1 = 0;
    #1 chk("T8", o1(), 8'b0000_10);
    cyc();
    #1 chk("T9_wb", o1(), 8'b0000_11);
    cyc();
    #1 chk("T10", o1(), 8'b0000_00);

    // MUL_LAT=2 instance
    do_reset();
    cyc();
    mreq = 1; id_rd = 4;
    #1 chk("L2_T0", {6'b0, s2_start, s2_busy},
           8'b10);
    cyc();
    mreq = 0; id_rd = 0;
    #1 chk("L2_T1", {6'b0, s2_busy, s2_wb},
           8'b10);
    cyc();
    #1 chk("L2_T2", {6'b0, s2_busy, s2_wb},
           8'b11);
    chk("L2_rd", {3'b0, s2_mrd}, 8'd4);
    cyc();
    #1 chk("L2_T3", {6'b0, s2_busy, s2_wb},
           8'b00);

    // Reset mid-BUSY abandons the MUL
    do_reset();
    cyc();
    mreq = 1; id_rd = 6;
    cyc();
    mreq = 0; id_rd = 0;
    cyc();
    #1 chk("rb_busy", o1(), 8'b0000_10);
    br = 1; rs1 = 6;
    rst_i = 1'b0;
    #1 chk("rb_outs", o1(), 8'h00);
    chk("rb_rd", {3'b0, mrd_o}, 8'h00);
    cyc();
    idle_in();
    rst_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      #1 chk("rb_after", o1(), 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RISC-V core. Sits beside the forwarding unit.
- Detects load-use hazards and taken-branch flushes.
- Owns the multi-cycle multiplier: issue, busy tracking, structural and RAW stalls against its pending destination, and the writeback pulse.
- Drives PC/IF-ID hold, ID-EX bubble and IF-ID flush.

Parameters:
- MUL_LAT, 4, cycles from MulStart_o pulse to MulWB_o pulse; legal range 2..15.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  reset; asynchronous, active-low
- IFID_rs1_i  input  5  rs1 of instruction in ID
- IFID_rs2_i  input  5  rs2 of instruction in ID
- IFID_UsesRs2_i  input  1  ID instruction reads rs2
- ID_rd_i  input  5  rd of instruction in ID
- ID_MulReq_i  input  1  ID instruction is a MUL
- IDEX_rd_i  input  5  rd of instruction in EX
- IDEX_MemRead_i  input  1  EX instruction is a load
- EX_BranchTaken_i  input  1  branch in EX resolved taken
- Stall_o  output  1  hold PC and IF/ID
- Bubble_o  output  1  zero control signals into ID/EX
- Flush_o  output  1  clear IF/ID
- MulStart_o  output  1  one-cycle issue pulse to multiplier
- MulBusy_o  output  1  multiplier occupied
- MulWB_o  output  1  one-cycle pulse: multiplier result written via dedicated register-file write port
- MulRd_o  output  5  destination of in-flight MUL

Behaviour:

Reset (rst_i=0, async):
- State IDLE, counter 0, MulRd_o=0.
- All outputs 0 immediately.
- Reset mid-operation abandons the in-flight MUL; no MulWB_o is issued.

FSM states and transitions:
- IDLE -> BUSY on MulStart_o.
- BUSY -> WB when counter==1.
- WB -> IDLE unconditionally.

Counter:
- Loaded with MUL_LAT-1 on MulStart_o.
- Decrements each cycle in BUSY.
- MulRd_o latches ID_rd_i on MulStart_o and holds until the next start.

Timing (MulStart_o in cycle T):
- MulBusy_o=1 in cycles T+1 .. T+MUL_LAT.
- MulWB_o=1 in cycle T+MUL_LAT only.
- IDLE again at T+MUL_LAT+1.
- MulBusy_o = (state != IDLE).

Hazard terms (combinational):
- match(r) = (r != 0) & (r == IFID_rs1_i | (IFID_UsesRs2_i & r == IFID_rs2_i)).
- lu = IDEX_MemRead_i & match(IDEX_rd_i).
- raw = (state BUSY or WB) & match(MulRd_o). Held through WB because the register file captures at the clock edge.
- st = ID_MulReq_i & (state != IDLE).
- hz = lu | raw | st.

Outputs and priority:
- Flush_o = EX_BranchTaken_i.
- Stall_o = hz & ~EX_BranchTaken_i. A taken branch overrides all stalls because the ID instruction is wrong-path.
- Bubble_o = hz | EX_BranchTaken_i.
- MulStart_o = ID_MulReq_i & (state == IDLE) & ~lu & ~EX_BranchTaken_i.

Boundary conditions:
- A stalled MUL retries every cycle and issues in the first cycle its conditions clear.
- A MUL in ID with ID_rd_i==0 still issues and occupies the unit. Its writeback is harmless, and it creates no RAW stall.
- A branch flush never cancels an in-flight MUL; that MUL is older than the branch.
- A MUL in ID during WB stalls one cycle (structural) and issues the cycle after. There is no back-to-back overlap.
- lu and raw may assert simultaneously; there is a single stall, and the outputs are identical.

Test Plan:
1. Reset: drive rst_i=0 mid-BUSY with MUL_LAT=4 -> all outputs 0 at once; no MulWB_o after release; MulBusy_o=0.
2. Load-use: IDEX_MemRead_i=1, IDEX_rd_i=5, IFID_rs2_i=5, IFID_UsesRs2_i=1 -> Stall_o=Bubble_o=1. Same with IFID_UsesRs2_i=0 -> no stall. Same with IDEX_rd_i=0 -> no stall.
3. MUL timing: ID_MulReq_i=1, ID_rd_i=7 at T, MUL_LAT=4 ->
   - MulStart_o at T.
   - MulBusy_o T+1..T+4.
   - MulWB_o only at T+4, with MulRd_o=7.
   - A dependent (rs1=7) instruction in ID stalls T+1..T+4 and proceeds at T+5.
4. Structural: a second MUL enters ID at T+2 -> Stall_o=1 through T+4; MulStart_o at T+5.
5. Branch priority: EX_BranchTaken_i=1 with lu=1 and ID_MulReq_i=1 in IDLE -> Flush_o=1, Bubble_o=1, Stall_o=0, MulStart_o=0. The same branch during BUSY leaves MulWB_o timing unchanged.
6. MUL_LAT=2 build: start at T -> BUSY at T+1, MulWB_o at T+2, IDLE at T+3.
